// File: rtl/alu_cmd_driver.sv
// ALU command master: latches a command, iterates w->inB for cmd_rep extra passes, returns w/zer/neg; res_valid at T0+cmd_rep+1.
// Result held until res_ready; no accept while busy. ALU_CMD_DRIVER_ZERO_EXIT_EN ends iteration early on zer and adds res_left.
module alu_cmd_driver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_c,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] inA,
  output logic [WIDTH-1:0] inB,
  output logic [2:0]       opc,
  output logic             inC,
  input  logic [WIDTH-1:0] w,
  input  logic             zer,
  input  logic             neg,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_w,
  output logic             res_zer,
`ifdef ALU_CMD_DRIVER_ZERO_EXIT_EN
  output logic [CNT_W-1:0] res_left,
`endif
  output logic             res_neg
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rep_cnt;
  logic             exec_done;
  logic             cmd_fire;
  logic             res_fire;

`ifdef ALU_CMD_DRIVER_ZERO_EXIT_EN
  // A zero result short-circuits the remaining iterations.
  assign exec_done = (rep_cnt == '0) || zer;
`else
  assign exec_done = (rep_cnt == '0);
`endif

  assign cmd_fire = cmd_valid && cmd_ready;
  assign res_fire = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (res_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    res_valid = (state == RESP);
  end

  // ALU-facing registers only move on accept or feedback, so they hold in IDLE/RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      inA     <= '0;
      inB     <= '0;
      opc     <= 3'b000;
      inC     <= 1'b0;
      rep_cnt <= '0;
      res_w   <= '0;
      res_zer <= 1'b0;
      res_neg <= 1'b0;
    end else if (state == IDLE) begin
      if (cmd_fire) begin
        inA     <= cmd_a;
        inB     <= cmd_b;
        opc     <= cmd_opc;
        inC     <= cmd_c;
        rep_cnt <= cmd_rep;
      end
    end else if (state == EXEC) begin
      if (exec_done) begin
        res_w   <= w;
        res_zer <= zer;
        res_neg <= neg;
      end else begin
        inB     <= w;
        rep_cnt <= rep_cnt - CNT_ONE;
      end
    end
  end

`ifdef ALU_CMD_DRIVER_ZERO_EXIT_EN
  always_ff @(posedge clk) begin
    if (rst)                           res_left <= '0;
    else if (state == EXEC && exec_done) res_left <= rep_cnt;
  end
`endif

endmodule
